// File: rtl/rice_core_pkg.sv
// Shared Zicsr definitions for the rice core: CSR operation encodings (funct3)
// and the CSR address fields that carry the privilege and access attributes.
package rice_core_pkg;

    typedef enum logic [2:0] {
        CSR_OP_RW  = 3'd1,
        CSR_OP_RS  = 3'd2,
        CSR_OP_RC  = 3'd3,
        CSR_OP_RWI = 3'd5,
        CSR_OP_RSI = 3'd6,
        CSR_OP_RCI = 3'd7
    } rice_core_csr_op;

    localparam int CSR_PRIV_MSB   = 9;
    localparam int CSR_PRIV_LSB   = 8;
    localparam int CSR_ACCESS_MSB = 11;
    localparam int CSR_ACCESS_LSB = 10;
    localparam logic [1:0] CSR_ACCESS_READ_ONLY = 2'b11;

    function automatic logic csr_op_is_swap(input rice_core_csr_op op);
        return (op == CSR_OP_RW) || (op == CSR_OP_RWI);
    endfunction

    function automatic logic csr_op_is_imm(input rice_core_csr_op op);
        return (op == CSR_OP_RWI) || (op == CSR_OP_RSI) || (op == CSR_OP_RCI);
    endfunction

endpackage

// File: rtl/rice_bus_if.sv
// Core-environment CSR bus: valid/ready request channel and a response channel.
// Writes are non-posted, so every accepted request gets exactly one response.
interface rice_bus_if #(
    parameter int XLEN = 32
);
    logic            request_valid;
    logic            request_ready;
    logic [11:0]     request_address;
    logic            request_write;
    logic [XLEN-1:0] request_write_data;
    logic            response_valid;
    logic [XLEN-1:0] response_read_data;
    logic            response_error;

    modport master (
        output request_valid,
        output request_address,
        output request_write,
        output request_write_data,
        input  request_ready,
        input  response_valid,
        input  response_read_data,
        input  response_error
    );

    modport slave (
        input  request_valid,
        input  request_address,
        input  request_write,
        input  request_write_data,
        output request_ready,
        output response_valid,
        output response_read_data,
        output response_error
    );
endinterface

// File: rtl/rice_core_csr_alu.sv
// Write-data generator for Zicsr read-modify-write: swap, set-bits or clear-bits
// of the old CSR value with the (register or immediate) source operand.
module rice_core_csr_alu
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  rice_core_csr_op op,
    input  logic [XLEN-1:0] old_value,
    input  logic [XLEN-1:0] src_value,
    output logic [XLEN-1:0] write_data
);

    // Select the read-modify-write combination for the operation.
    always_comb begin
        write_data = src_value;
        case (op)
            CSR_OP_RW, CSR_OP_RWI: write_data = src_value;
            CSR_OP_RS, CSR_OP_RSI: write_data = old_value | src_value;
            CSR_OP_RC, CSR_OP_RCI: write_data = old_value & ~src_value;
            default:               write_data = src_value;
        endcase
    end

endmodule

// File: rtl/rice_core_csr_access.sv
// Execute-stage CSR access unit: runs one Zicsr instruction as a bus read/modify/write.
// Optional macro RICE_CORE_CSR_ACCESS_CHECK_EN adds privilege/read-only checking.
module rice_core_csr_access
    import rice_core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_enable,
    input  logic            i_valid,
    output logic            o_ready,
    input  rice_core_csr_op i_op,
    input  logic [11:0]     i_address,
    input  logic [XLEN-1:0] i_rs1_value,
    input  logic [4:0]      i_rs1_index,
    input  logic [4:0]      i_rd_index,
    input  logic [1:0]      i_privilege_level,
    output logic            o_done,
    output logic [XLEN-1:0] o_rd_value,
    output logic            o_illegal,
    rice_bus_if.master      csr_if
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_RD_REQ = 3'd2,
        ST_RD_RSP = 3'd3,
        ST_WR_REQ = 3'd4,
        ST_WR_RSP = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    state_t          state_r;
    rice_core_csr_op op_r;
    logic [11:0]     address_r;
    logic [XLEN-1:0] src_r;
    logic [XLEN-1:0] old_r;
    logic            rd_zero_r;
    logic            do_read_r;
    logic            do_write_r;
    logic            outstanding_r;
    logic            req_valid_r;
    logic            req_write_r;
    logic [XLEN-1:0] req_wdata_r;
    logic            done_r;
    logic            illegal_r;
    logic [XLEN-1:0] rd_value_r;

    logic            accept_s;
    logic            is_swap_s;
    logic [XLEN-1:0] src_sel_s;
    logic [XLEN-1:0] old_sel_s;
    logic [XLEN-1:0] wdata_s;
    logic            fault_s;

    // A response still owed by the bus blocks new requests, so nothing stale can
    // be mistaken for the reply to the next instruction.
    assign o_ready  = (state_r == ST_IDLE) && !outstanding_r && i_enable;
    assign accept_s = i_valid && o_ready;

    assign is_swap_s = csr_op_is_swap(i_op);

    // Pick the register operand or the zero-extended immediate.
    always_comb begin
        if (csr_op_is_imm(i_op)) begin
            src_sel_s = {{(XLEN-5){1'b0}}, i_rs1_index};
        end else begin
            src_sel_s = i_rs1_value;
        end
    end

    // The write directly after a read uses the data arriving this cycle.
    always_comb begin
        if (state_r == ST_RD_RSP) begin
            old_sel_s = csr_if.response_read_data;
        end else begin
            old_sel_s = old_r;
        end
    end

    rice_core_csr_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op         (op_r),
        .old_value  (old_sel_s),
        .src_value  (src_r),
        .write_data (wdata_s)
    );

`ifdef RICE_CORE_CSR_ACCESS_CHECK_EN
    assign fault_s = (address_r[CSR_PRIV_MSB:CSR_PRIV_LSB] > i_privilege_level) ||
                     ((address_r[CSR_ACCESS_MSB:CSR_ACCESS_LSB] == CSR_ACCESS_READ_ONLY) && do_write_r);
`else
    logic unused_privilege_s;
    assign unused_privilege_s = ^i_privilege_level;
    assign fault_s            = 1'b0;
`endif

    assign csr_if.request_valid      = req_valid_r;
    assign csr_if.request_address    = address_r;
    assign csr_if.request_write      = req_write_r;
    assign csr_if.request_write_data = req_wdata_r;

    assign o_done     = done_r;
    assign o_illegal  = illegal_r;
    assign o_rd_value = rd_value_r;

    // Track one accepted-but-unanswered bus request, independent of i_enable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            outstanding_r <= 1'b0;
        end else if (csr_if.request_valid && csr_if.request_ready) begin
            outstanding_r <= 1'b1;
        end else if (csr_if.response_valid) begin
            outstanding_r <= 1'b0;
        end
    end

    // Transaction sequencer with registered bus request and result outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            op_r        <= CSR_OP_RW;
            address_r   <= 12'h000;
            src_r       <= {XLEN{1'b0}};
            old_r       <= {XLEN{1'b0}};
            rd_zero_r   <= 1'b0;
            do_read_r   <= 1'b0;
            do_write_r  <= 1'b0;
            req_valid_r <= 1'b0;
            req_write_r <= 1'b0;
            req_wdata_r <= {XLEN{1'b0}};
            done_r      <= 1'b0;
            illegal_r   <= 1'b0;
            rd_value_r  <= {XLEN{1'b0}};
        end else if (!i_enable) begin
            state_r     <= ST_IDLE;
            req_valid_r <= 1'b0;
            done_r      <= 1'b0;
            illegal_r   <= 1'b0;
            rd_value_r  <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r       <= i_op;
                        address_r  <= i_address;
                        src_r      <= src_sel_s;
                        old_r      <= {XLEN{1'b0}};
                        rd_zero_r  <= (i_rd_index == 5'd0);
                        do_read_r  <= !(is_swap_s && (i_rd_index == 5'd0));
                        do_write_r <= is_swap_s || (i_rs1_index != 5'd0);
                        state_r    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (fault_s) begin
                        done_r     <= 1'b1;
                        illegal_r  <= 1'b1;
                        rd_value_r <= {XLEN{1'b0}};
                        state_r    <= ST_DONE;
                    end else if (do_read_r) begin
                        req_valid_r <= 1'b1;
                        req_write_r <= 1'b0;
                        state_r     <= ST_RD_REQ;
                    end else begin
                        req_valid_r <= 1'b1;
                        req_write_r <= 1'b1;
                        req_wdata_r <= wdata_s;
                        state_r     <= ST_WR_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (csr_if.request_ready) begin
                        req_valid_r <= 1'b0;
                        state_r     <= ST_RD_RSP;
                    end
                end
                ST_RD_RSP: begin
                    if (csr_if.response_valid) begin
                        if (csr_if.response_error) begin
                            done_r     <= 1'b1;
                            illegal_r  <= 1'b1;
                            rd_value_r <= {XLEN{1'b0}};
                            state_r    <= ST_DONE;
                        end else if (do_write_r) begin
                            old_r       <= csr_if.response_read_data;
                            req_valid_r <= 1'b1;
                            req_write_r <= 1'b1;
                            req_wdata_r <= wdata_s;
                            state_r     <= ST_WR_REQ;
                        end else begin
                            old_r      <= csr_if.response_read_data;
                            done_r     <= 1'b1;
                            illegal_r  <= 1'b0;
                            rd_value_r <= rd_zero_r ? {XLEN{1'b0}} : csr_if.response_read_data;
                            state_r    <= ST_DONE;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (csr_if.request_ready) begin
                        req_valid_r <= 1'b0;
                        state_r     <= ST_WR_RSP;
                    end
                end
                ST_WR_RSP: begin
                    if (csr_if.response_valid) begin
                        done_r     <= 1'b1;
                        illegal_r  <= csr_if.response_error;
                        rd_value_r <= (csr_if.response_error || rd_zero_r) ? {XLEN{1'b0}} : old_r;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r     <= 1'b0;
                    illegal_r  <= 1'b0;
                    rd_value_r <= {XLEN{1'b0}};
                    state_r    <= ST_IDLE;
                end
                default: begin
                    req_valid_r <= 1'b0;
                    done_r      <= 1'b0;
                    illegal_r   <= 1'b0;
                    rd_value_r  <= {XLEN{1'b0}};
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rice_core_csr_access.sv
// Directed bench for rice_core_csr_access: vector table against a CSR-bus slave model,
// plus a stalled-write / enable-drop / drain sequence.
module tb_rice_core_csr_access;
    import rice_core_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            valid;
    logic            ready;
    rice_core_csr_op op;
    logic [11:0]     addr;
    logic [31:0]     rs1_value;
    logic [4:0]      rs1_index;
    logic [4:0]      rd_index;
    logic [1:0]      priv;
    logic            done;
    logic [31:0]     rd_value;
    logic            illegal;

    always #5 clk = ~clk;

    rice_bus_if #(.XLEN(XLEN)) bus ();

    rice_core_csr_access #(.XLEN(XLEN)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_enable          (en),
        .i_valid           (valid),
        .o_ready           (ready),
        .i_op              (op),
        .i_address         (addr),
        .i_rs1_value       (rs1_value),
        .i_rs1_index       (rs1_index),
        .i_rd_index        (rd_index),
        .i_privilege_level (priv),
        .o_done            (done),
        .o_rd_value        (rd_value),
        .o_illegal         (illegal),
        .csr_if            (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string what, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", what, got, exp);
        end
    endtask

    // ---------------- CSR bus slave model ----------------
    int          stall_wr   = 0;
    int          resp_delay = 0;
    int          rd_cnt     = 0;
    int          wr_cnt     = 0;
    int          rsp_cnt    = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] mem [0:4095];

    initial begin
        bit          hs, hs_write, pend, prev_stall, rsp_err;
        logic [11:0] hs_addr, st_addr;
        logic [31:0] hs_wdata, st_wdata, rsp_data;
        int          wait_c, stall_left;
        bus.request_ready      = 1'b0;
        bus.response_valid     = 1'b0;
        bus.response_read_data = 32'h0;
        bus.response_error     = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[12'h340] = 32'h12345678;
        mem[12'h300] = 32'h00001888;
        hs = 1'b0; pend = 1'b0; prev_stall = 1'b0; rsp_err = 1'b0;
        hs_addr = 12'h0; hs_write = 1'b0; hs_wdata = 32'h0; rsp_data = 32'h0;
        st_addr = 12'h0; st_wdata = 32'h0; wait_c = 0; stall_left = 0;
        forever begin
            @(negedge clk);
            bus.response_valid = 1'b0;
            bus.response_error = 1'b0;
            if (hs) begin
                hs = 1'b0;
                if (hs_write) begin
                    wr_cnt++;
                    last_wdata = hs_wdata;
                    rsp_err    = (hs_addr == 12'h7C0) || (hs_addr[11:10] == 2'b11);
                    rsp_data   = 32'h0;
                    if (!rsp_err) mem[hs_addr] = hs_wdata;
                end else begin
                    rd_cnt++;
                    rsp_err  = (hs_addr == 12'h7C0);
                    rsp_data = rsp_err ? 32'h0 : mem[hs_addr];
                end
                pend   = 1'b1;
                wait_c = resp_delay;
            end
            if (pend) begin
                if (wait_c == 0) begin
                    bus.response_valid     = 1'b1;
                    bus.response_read_data = rsp_data;
                    bus.response_error     = rsp_err;
                    pend = 1'b0;
                    rsp_cnt++;
                end else begin
                    wait_c--;
                end
            end
            if (prev_stall && bus.request_valid) begin
                check("req_stable_addr", {20'h0, bus.request_address}, {20'h0, st_addr});
                check("req_stable_wdata", bus.request_write_data, st_wdata);
            end
            if (bus.request_valid && bus.request_write && !prev_stall) stall_left = stall_wr;
            if (bus.request_valid) begin
                if (bus.request_write && stall_left > 0) begin
                    bus.request_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.request_ready = 1'b1;
                end
            end else begin
                bus.request_ready = 1'b0;
            end
            prev_stall = bus.request_valid && !bus.request_ready;
            st_addr    = bus.request_address;
            st_wdata   = bus.request_write_data;
            hs         = bus.request_valid && bus.request_ready;
            hs_addr    = bus.request_address;
            hs_write   = bus.request_write;
            hs_wdata   = bus.request_write_data;
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [11:0] addr;
        logic [31:0] rs1_value;
        logic [4:0]  rs1_index;
        logic [4:0]  rd_index;
        logic [1:0]  priv;
        logic [31:0] exp_rd;
        logic        exp_illegal;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_wdata;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [2:0] o, input logic [11:0] a,
                                input logic [31:0] rv, input logic [4:0] ri, input logic [4:0] di,
                                input logic [1:0] pl, input logic [31:0] erd, input logic eill,
                                input int elat, input int er, input int ew, input logic [31:0] ewd);
        vec_t v;
        v.name = name; v.op = o; v.addr = a; v.rs1_value = rv; v.rs1_index = ri;
        v.rd_index = di; v.priv = pl; v.exp_rd = erd; v.exp_illegal = eill;
        v.exp_lat = elat; v.exp_reads = er; v.exp_writes = ew; v.exp_wdata = ewd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int lat, r0, w0;
        bit got;
        lat = 0;
        @(negedge clk);
        while (!ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({v.name, "_ready"}, {31'h0, ready}, 32'd1);
        r0 = rd_cnt;
        w0 = wr_cnt;
        op        = rice_core_csr_op'(v.op);
        addr      = v.addr;
        rs1_value = v.rs1_value;
        rs1_index = v.rs1_index;
        rd_index  = v.rd_index;
        priv      = v.priv;
        valid     = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge clk);
            valid = 1'b0;
            lat++;
            got = done;
        end
        check({v.name, "_done"}, {31'h0, got}, 32'd1);
        check({v.name, "_rd"}, rd_value, v.exp_rd);
        check({v.name, "_illegal"}, {31'h0, illegal}, {31'h0, v.exp_illegal});
        check({v.name, "_latency"}, lat, v.exp_lat);
        check({v.name, "_reads"}, rd_cnt - r0, v.exp_reads);
        check({v.name, "_writes"}, wr_cnt - w0, v.exp_writes);
        if (v.exp_writes > 0) check({v.name, "_wdata"}, last_wdata, v.exp_wdata);
        @(negedge clk);
        check({v.name, "_done_pulse"}, {31'h0, done}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   k, wr_seen, done_seen, rsp0;

        // name op addr rs1_value rs1_idx rd prv | exp_rd ill lat reads writes wdata
        vecs.push_back(mk("csrrw_mscratch", 3'd1, 12'h340, 32'hDEADBEEF, 5'd6, 5'd5, 2'd3,
                          32'h12345678, 1'b0, 6, 1, 1, 32'hDEADBEEF));
        vecs.push_back(mk("csrrs_x0_mstatus", 3'd2, 12'h300, 32'h0000FFFF, 5'd0, 5'd7, 2'd3,
                          32'h00001888, 1'b0, 4, 1, 0, 32'h0));
        vecs.push_back(mk("csrrci_mstatus", 3'd7, 12'h300, 32'hFFFFFFFF, 5'd8, 5'd8, 2'd3,
                          32'h00001888, 1'b0, 6, 1, 1, 32'h00001880));
`ifdef RICE_CORE_CSR_ACCESS_CHECK_EN
        vecs.push_back(mk("csrrw_readonly", 3'd1, 12'hF14, 32'h00000055, 5'd3, 5'd0, 2'd3,
                          32'h0, 1'b1, 2, 0, 0, 32'h0));
`else
        vecs.push_back(mk("csrrw_readonly", 3'd1, 12'hF14, 32'h00000055, 5'd3, 5'd0, 2'd3,
                          32'h0, 1'b1, 4, 0, 1, 32'h00000055));
`endif
        vecs.push_back(mk("csrrs_bus_error", 3'd2, 12'h7C0, 32'h00000001, 5'd4, 5'd9, 2'd3,
                          32'h0, 1'b1, 4, 1, 0, 32'h0));
        vecs.push_back(mk("csrrsi_set", 3'd6, 12'h340, 32'h0, 5'h10, 5'd10, 2'd3,
                          32'hDEADBEEF, 1'b0, 6, 1, 1, 32'hDEADBEFF));
        vecs.push_back(mk("csrrc_clear", 3'd3, 12'h340, 32'hFF000000, 5'd2, 5'd11, 2'd3,
                          32'hDEADBEFF, 1'b0, 6, 1, 1, 32'h00ADBEFF));
        vecs.push_back(mk("csrrwi_rd0", 3'd5, 12'h340, 32'h0, 5'h1F, 5'd0, 2'd3,
                          32'h0, 1'b0, 4, 0, 1, 32'h0000001F));
        vecs.push_back(mk("csrrw_rs1_x0", 3'd1, 12'h340, 32'hA5A5A5A5, 5'd0, 5'd12, 2'd3,
                          32'h0000001F, 1'b0, 6, 1, 1, 32'hA5A5A5A5));
`ifdef RICE_CORE_CSR_ACCESS_CHECK_EN
        vecs.push_back(mk("csrrs_low_priv", 3'd2, 12'h340, 32'h0, 5'd0, 5'd1, 2'd1,
                          32'h0, 1'b1, 2, 0, 0, 32'h0));
`else
        vecs.push_back(mk("csrrs_low_priv", 3'd2, 12'h340, 32'h0, 5'd0, 5'd1, 2'd1,
                          32'hA5A5A5A5, 1'b0, 4, 1, 0, 32'h0));
`endif

        rst_n = 1'b0; en = 1'b1; valid = 1'b0; op = CSR_OP_RW; addr = 12'h0;
        rs1_value = 32'h0; rs1_index = 5'd0; rd_index = 5'd0; priv = 2'd3;
        repeat (3) @(negedge clk);
        check("reset_done", {31'h0, done}, 32'd0);
        check("reset_illegal", {31'h0, illegal}, 32'd0);
        check("reset_rd_value", rd_value, 32'h0);
        check("reset_req_valid", {31'h0, bus.request_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'h0, ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stalled write, enable dropped on the cycle the write is accepted by the bus.
        stall_wr   = 3;
        resp_delay = 3;
        @(negedge clk);
        k = 0;
        while (!ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        op = CSR_OP_RW; addr = 12'h340; rs1_value = 32'h00000011;
        rs1_index = 5'd1; rd_index = 5'd1; priv = 2'd3; valid = 1'b1;
        wr_seen = 0; done_seen = 0; k = 0;
        while (wr_seen < 4 && k < 40) begin
            @(negedge clk);
            valid = 1'b0;
            k++;
            if (done) done_seen++;
            if (bus.request_valid && bus.request_write) wr_seen++;
        end
        check("stall_wr_cycles", wr_seen, 4);
        en   = 1'b0;
        rsp0 = rsp_cnt;
        @(negedge clk);
        en = 1'b1;
        #1;
        check("drain_ready_low", {31'h0, ready}, 32'd0);
        if (done) done_seen++;
        k = 0;
        while (!ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
            if (done) done_seen++;
        end
        check("drain_ready_back", {31'h0, ready}, 32'd1);
        check("drain_rsp_before_ready", rsp_cnt - rsp0, 32'd1);
        check("abandon_no_done", done_seen, 32'd0);
        check("abandon_wdata", last_wdata, 32'h00000011);
        stall_wr   = 0;
        resp_delay = 0;
        run_vec(mk("after_drain", 3'd2, 12'h340, 32'h0, 5'd0, 5'd2, 2'd3,
                   32'h00000011, 1'b0, 4, 1, 0, 32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rice_core_csr_access.md
Name: rice_core_csr_access

Overview:
- Execute-stage CSR access unit and the bus master that drives the core-environment CSR bus (rice_bus_if, 12-bit address, XLEN data).
- Executes one Zicsr instruction (CSRRW/S/C, CSRRWI/SI/CI) as a sequenced read-modify-write transaction.
- Returns the old CSR value for rd.
- Raises an illegal-instruction exception on privilege, read-only or bus-error faults; the exception feeds the trap logic.

Parameters:
- XLEN, 32, data width of CSR values and bus.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_enable  input  1  core enable; low forces FSM to IDLE, drops outstanding results.
- i_valid  input  1  CSR instruction request from execute.
- o_ready  output  1  request accepted; high only in IDLE.
- i_op  input  rice_core_csr_op (3)  funct3: RW=1, RS=2, RC=3, RWI=5, RSI=6, RCI=7.
- i_address  input  12  CSR address.
- i_rs1_value  input  XLEN  rs1 operand (register forms).
- i_rs1_index  input  5  rs1 index / uimm (immediate forms, zero-extended).
- i_rd_index  input  5  destination index.
- i_privilege_level  input  2  current privilege level.
- o_done  output  1  one-cycle completion pulse.
- o_rd_value  output  XLEN  old CSR value, valid with o_done.
- o_illegal  output  1  illegal-instruction exception, valid with o_done.
- csr_if  rice_bus_if.master  —  request (valid/ready, address, write, write_data) and response (valid, read_data, error); writes are non-posted.

Behaviour:
- Reset / i_enable low:
  - State IDLE.
  - o_done=0, o_illegal=0, o_rd_value=0.
  - No bus request.
- Accept: i_valid && o_ready registers op, address, source (i_rs1_value or zero-extended uimm), rd_zero=(i_rd_index==0), src_zero=(i_rs1_index==0).
- do_read = !(RW/RWI && rd_zero). do_write = RW/RWI || !src_zero.
- States:
  - IDLE.
  - CHECK: one cycle.
  - RD_REQ: request_valid, write=0, held until ready.
  - RD_RSP: wait for response_valid.
  - WR_REQ: request_valid, write=1, held until ready.
  - WR_RSP: wait for response_valid.
  - DONE: o_done=1 for one cycle, then IDLE.
- CHECK transitions:
  - Fault -> DONE with o_illegal=1.
  - Else do_read -> RD_REQ.
  - Else -> WR_REQ.
- RD_RSP transitions:
  - error -> DONE, illegal.
  - Else latch read_data as old.
  - Then do_write -> WR_REQ, else DONE.
- WR_RSP: error -> DONE, illegal; else DONE.
- Write data:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
  - When do_read=0, old=0 (RW only, so no effect).
- o_rd_value = old; 0 when illegal or rd_zero.
- Request fields are stable while valid && !ready.
- Latency with zero-wait bus: read+write = 6 cycles accept-to-done; read-only or write-only = 4.
- Write is never issued after a failed read. No bus access at all on a CHECK fault.
- i_enable falling mid-transaction: abandon immediately, no o_done. Outstanding bus response is drained silently before IDLE accepts.

Optional Feature:
- Macro: RICE_CORE_CSR_ACCESS_CHECK_EN.
- Defined: CHECK flags a fault when address[9:8] > i_privilege_level, or when address[11:10]==2'b11 && do_write.
- Undefined: CHECK never faults; faults come only from bus error responses. Latency is identical.

Decomposition:
- rice_core_pkg: rice_core_csr_op enum, CSR address field constants (privilege bits 9:8, access bits 11:10).
- FSM state enum stays local to the module.
- Sub-module rice_core_csr_alu: combinational RW/RS/RC write-data generation.

Test Plan:
- CSRRW x5, 0x340, rs1=0xDEADBEEF, mscratch=0x12345678 -> read then write 0xDEADBEEF; o_rd_value=0x12345678; 6-cycle latency.
- CSRRS x0-rs1 (rs1_index=0), 0x300 -> read only, no write request; o_rd_value=mstatus.
- CSRRCI uimm=0x8, 0x300, mstatus=0x1888 -> write data 0x1880.
- CSRRW rd=x0, 0xF14 (read-only), CHECK_EN defined -> no bus access, o_illegal=1, o_rd_value=0.
- CSRRS with rs1≠0, 0x7C0 unmapped, dummy slave returns error on read -> o_illegal=1, no write request issued.
- Bus ready held low 3 cycles on write, i_enable dropped in WR_REQ -> no o_done; next request is accepted only after the bus has drained.
